// File: rtl/usb2_ep_writer.sv
// Streams application bytes into the double-buffered USB endpoint buffer and
// runs the commit/ack/swap handshake once per packet (including zero-length ones).
module usb2_ep_writer #(
  parameter int MAX_PKT  = 512,
  parameter bit AUTO_ZLP = 1'b1
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        flush,
  output logic [8:0]  buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [9:0]  buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic [15:0] pkt_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMMIT,
    ST_ACK,
    ST_DRAIN
  } state_t;

  localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_len;
  logic        r_zlp_pend;
  logic        r_wren;
  logic [8:0]  r_addr;
  logic [7:0]  r_data;
  logic [15:0] r_pkt_count;

  logic        w_accept;
  logic [9:0]  w_len_inc;
  logic        w_full;
  logic        w_close_beat;

  assign w_accept     = (r_state == ST_FILL) && s_valid;
  assign w_len_inc    = r_len + 10'd1;
  assign w_full       = (w_len_inc == MAX_LEN);
  assign w_close_beat = w_accept && (w_full || s_last || flush);

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (buf_in_ready) begin
          w_state_nxt = r_zlp_pend ? ST_COMMIT : ST_FILL;
        end
      end
      ST_FILL: begin
        // A flush with no beat closes the packet at its current length, possibly zero.
        if (w_close_beat || (!s_valid && flush)) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (buf_in_commit_ack) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!buf_in_commit_ack) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Ready stays high through the endpoint's swap cycle; wait for it to drop.
        if (!buf_in_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_len       <= 10'd0;
      r_zlp_pend  <= 1'b0;
      r_wren      <= 1'b0;
      r_addr      <= 9'd0;
      r_data      <= 8'd0;
      r_pkt_count <= 16'd0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (buf_in_ready) begin
            r_len <= 10'd0;
            if (r_zlp_pend) begin
              r_zlp_pend <= 1'b0;
            end
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            r_wren <= 1'b1;
            r_addr <= r_len[8:0];
            r_data <= s_data;
            r_len  <= w_len_inc;
            if (w_full && s_last && AUTO_ZLP) begin
              r_zlp_pend <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          if (buf_in_commit_ack) begin
            r_pkt_count <= r_pkt_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready           = (r_state == ST_FILL);
  assign buf_in_commit     = (r_state == ST_COMMIT);
  assign buf_in_commit_len = buf_in_commit ? r_len : 10'd0;
  assign buf_in_addr       = r_addr;
  assign buf_in_data       = r_data;
  assign buf_in_wren       = r_wren;
  assign pkt_count         = r_pkt_count;
  assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb2_ep_writer.sv
// Bench for usb2_ep_writer: packet table plus endpoint model, write/commit scoreboards.
`timescale 1ns/1ps
module tb_usb2_ep_writer;

  logic        phy_clk;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        flush;
  logic        s_ready;
  logic [8:0]  buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_ready;
  logic        buf_in_commit;
  logic [9:0]  buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [15:0] pkt_count;
  logic        busy;

  logic        d2_hold, d2_rst;
  logic        d2_s_ready, d2_wren, d2_commit, d2_busy;
  logic [8:0]  d2_addr;
  logic [7:0]  d2_data;
  logic [9:0]  d2_len;
  logic [15:0] d2_pkt;

  logic ep_auto, ep_ack, ep_rdy, man_ack, man_rdy;
  assign buf_in_commit_ack = ep_auto ? ep_ack : man_ack;
  assign buf_in_ready      = ep_auto ? ep_rdy : man_rdy;
  assign d2_rst            = reset | d2_hold;

  usb2_ep_writer #(.MAX_PKT(512), .AUTO_ZLP(1'b1)) dut (
    .phy_clk(phy_clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .flush(flush), .buf_in_addr(buf_in_addr),
    .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren), .buf_in_ready(buf_in_ready),
    .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .buf_in_commit_ack(buf_in_commit_ack), .pkt_count(pkt_count), .busy(busy));

  usb2_ep_writer #(.MAX_PKT(512), .AUTO_ZLP(1'b0)) dut_nozlp (
    .phy_clk(phy_clk), .reset(d2_rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(d2_s_ready), .flush(flush), .buf_in_addr(d2_addr),
    .buf_in_data(d2_data), .buf_in_wren(d2_wren), .buf_in_ready(buf_in_ready),
    .buf_in_commit(d2_commit), .buf_in_commit_len(d2_len),
    .buf_in_commit_ack(buf_in_commit_ack), .pkt_count(d2_pkt), .busy(d2_busy));

  initial begin
    phy_clk = 1'b0;
    forever #5 phy_clk = ~phy_clk;
  end

  typedef struct packed { logic [8:0] a; logic [7:0] d; } wr_t;
  typedef struct { int nbytes; bit last; bit fl; int len0; int len1; } vec_t;

  wr_t wq[$];
  wr_t wq2[$];
  int  cq[$];
  int  cq2[$];

  int n_vec = 0;
  int n_err = 0;
  int wr_seen = 0;
  int commit_hi = 0;
  int exp_pkts = 0;
  bit prev_commit = 1'b0;
  bit prev_d2_commit = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string why);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // Endpoint: ack 3 cycles after commit seen, hold ack 4 cycles, then swap (ready low 2 cycles).
  initial begin : ep_model
    ep_ack = 1'b0;
    ep_rdy = 1'b1;
    forever begin
      @(negedge phy_clk);
      if (ep_auto && buf_in_commit) begin
        repeat (3) @(negedge phy_clk);
        ep_ack = 1'b1;
        repeat (4) @(negedge phy_clk);
        ep_ack = 1'b0;
        ep_rdy = 1'b0;
        repeat (2) @(negedge phy_clk);
        ep_rdy = 1'b1;
      end
    end
  end

  initial begin : monitor
    wr_t w;
    int  e;
    forever begin
      @(negedge phy_clk);
      if (buf_in_wren) begin
        wr_seen++;
        if (wq.size() == 0) fail("wren", "write with nothing expected");
        else begin
          w = wq.pop_front();
          chk("wr_addr", buf_in_addr, w.a);
          chk("wr_data", buf_in_data, w.d);
        end
      end
      if (buf_in_commit) begin
        commit_hi++;
        chk("s_ready_in_commit", s_ready, 0);
        if (!prev_commit) begin
          chk("commit_after_last_wr", wq.size(), 0);
          if (cq.size() == 0) fail("commit", "commit with nothing expected");
          else begin
            e = cq.pop_front();
            chk("commit_len", buf_in_commit_len, e);
          end
        end
      end
      prev_commit = buf_in_commit;
      if (d2_wren) begin
        if (wq2.size() == 0) fail("d2_wren", "write with nothing expected");
        else begin
          w = wq2.pop_front();
          chk("d2_wr_addr", d2_addr, w.a);
          chk("d2_wr_data", d2_data, w.d);
        end
      end
      if (d2_commit && !prev_d2_commit) begin
        if (cq2.size() == 0) fail("d2_commit", "commit with nothing expected");
        else begin
          e = cq2.pop_front();
          chk("d2_commit_len", d2_len, e);
        end
      end
      prev_d2_commit = d2_commit;
    end
  end

  // Called at a negedge; holds the beat until the DUT is in FILL, returns at the next negedge.
  task automatic send(input logic [7:0] d, input bit vld, input bit last, input bit fl,
                      input int addr);
    int t;
    t = 0;
    s_data = d; s_valid = vld; s_last = last; flush = fl;
    while (!s_ready && t < 5000) begin
      @(negedge phy_clk);
      t++;
    end
    if (!s_ready) fail("send_timeout", "s_ready never rose");
    if (vld) begin
      wq.push_back('{a: 9'(addr), d: d});
      if (!d2_hold) wq2.push_back('{a: 9'(addr), d: d});
    end
    @(negedge phy_clk);
    s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
  endtask

  task automatic settle();
    int t;
    t = 0;
    while ((cq.size() != 0 || !s_ready) && t < 5000) begin
      @(negedge phy_clk);
      t++;
    end
    if (cq.size() != 0 || !s_ready) fail("settle_timeout", "commits or FILL not reached");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin : main
    int ncom;
    logic [15:0] pk0;
    tbl[0] = '{3,   1'b1, 1'b0, 3,   -1};
    tbl[1] = '{520, 1'b0, 1'b1, 512, 8};
    tbl[2] = '{512, 1'b1, 1'b0, 512, 0};
    tbl[3] = '{0,   1'b0, 1'b1, 0,   -1};
    tbl[4] = '{5,   1'b0, 1'b1, 5,   -1};
    tbl[5] = '{1,   1'b1, 1'b0, 1,   -1};

    reset = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
    ep_auto = 1'b0; man_ack = 1'b0; man_rdy = 1'b0; d2_hold = 1'b0;
    repeat (3) @(negedge phy_clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wren", buf_in_wren, 0);
    chk("rst_commit", buf_in_commit, 0);
    chk("rst_addr", buf_in_addr, 0);
    chk("rst_data", buf_in_data, 0);
    chk("rst_commit_len", buf_in_commit_len, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d2_busy", d2_busy, 0);
    chk("rst_d2_s_ready", d2_s_ready, 0);
    reset = 1'b0;

    // Endpoint buffer not free: nothing moves.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      @(negedge phy_clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_busy", busy, 0);
    end
    s_valid = 1'b0;
    chk("bp_no_wren", wr_seen, 0);

    ep_auto = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_seen = 0;
      commit_hi = 0;
      ncom = (tbl[k].len1 >= 0) ? 2 : 1;
      cq.push_back(tbl[k].len0);
      if (tbl[k].len1 >= 0) cq.push_back(tbl[k].len1);
      if (!d2_hold) begin
        cq2.push_back(tbl[k].len0);
        if (tbl[k].len1 > 0) cq2.push_back(tbl[k].len1);
      end
      if (tbl[k].nbytes == 0) send(8'h00, 1'b0, 1'b0, tbl[k].fl, 0);
      for (int i = 0; i < tbl[k].nbytes; i++) begin
        send(8'(8'hA1 + i + 17 * k), 1'b1,
             tbl[k].last && (i == tbl[k].nbytes - 1),
             tbl[k].fl && (i == tbl[k].nbytes - 1), i % 512);
      end
      settle();
      exp_pkts += ncom;
      chk("tbl_wr_count", wr_seen, tbl[k].nbytes);
      chk("tbl_wq_empty", wq.size(), 0);
      chk("tbl_commit_hold", commit_hi, 4 * ncom);
      chk("tbl_pkt_count", pkt_count, exp_pkts);
      if (k == 2) begin
        chk("nozlp_pkt_count", d2_pkt, exp_pkts - 1);
        chk("nozlp_cq_empty", cq2.size(), 0);
        chk("nozlp_in_fill", d2_s_ready, 1);
        d2_hold = 1'b1;
      end
    end

    // Ack already high when COMMIT is entered, then held 10 cycles.
    ep_auto = 1'b0; man_rdy = 1'b1; man_ack = 1'b1;
    commit_hi = 0;
    pk0 = pkt_count;
    cq.push_back(1);
    send(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    repeat (10) @(negedge phy_clk);
    chk("preack_commit_pulse", commit_hi, 1);
    chk("preack_pkt_once", pkt_count, pk0 + 16'd1);
    chk("preack_busy_in_ack", busy, 1);
    exp_pkts++;
    man_ack = 1'b0;
    repeat (2) @(negedge phy_clk);
    man_rdy = 1'b0;
    repeat (2) @(negedge phy_clk);
    man_rdy = 1'b1;
    settle();
    chk("preack_pkt_final", pkt_count, exp_pkts);

    // Reset while the commit is pending.
    cq.push_back(2);
    send(8'h11, 1'b1, 1'b0, 1'b0, 0);
    send(8'h22, 1'b1, 1'b1, 1'b0, 1);
    repeat (2) @(negedge phy_clk);
    chk("pre_rst_commit", buf_in_commit, 1);
    reset = 1'b1;
    @(negedge phy_clk);
    chk("mid_rst_commit", buf_in_commit, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    chk("mid_rst_commit_len", buf_in_commit_len, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    reset = 1'b0;
    exp_pkts = 0;

    // Recovery packet after reset.
    ep_auto = 1'b1;
    cq.push_back(2);
    send(8'h33, 1'b1, 1'b0, 1'b0, 0);
    send(8'h44, 1'b1, 1'b1, 1'b0, 1);
    settle();
    chk("post_rst_pkt_count", pkt_count, 1);
    chk("post_rst_wq_empty", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb2_ep_writer.md
Name: usb2_ep_writer

Overview:
- Application-side producer for the double-buffered USB 2.0 endpoint buffer; the endpoint's IN-write/commit port is its partner.
- Accepts a byte stream with valid/ready flow control and writes each byte into the endpoint buffer at sequential addresses.
- Closes a packet on max-packet-size, end-of-transfer (s_last) or flush, then runs the commit/ack/swap handshake. Handles zero-length packets.
- Runs in the phy_clk domain, on the same clock as the endpoint.

Parameters:
- MAX_PKT, 512: bytes per full packet; legal range 1..512.
- AUTO_ZLP, 1: when 1, a transfer whose s_last lands exactly on MAX_PKT is followed automatically by a zero-length commit.

Ports:
- phy_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final byte of a transfer; meaningful only with s_valid.
- s_ready  out  1  byte accepted on any cycle where s_valid & s_ready.
- flush  in  1  level; closes the current packet, including a zero-byte packet.
- buf_in_addr  out  9  endpoint write address.
- buf_in_data  out  8  endpoint write data.
- buf_in_wren  out  1  endpoint write strobe.
- buf_in_ready  in  1  current endpoint buffer free.
- buf_in_commit  out  1  commit request; a level held until acknowledged.
- buf_in_commit_len  out  10  committed byte count, 0..512.
- buf_in_commit_ack  in  1  multi-cycle acknowledge pulse from the endpoint.
- pkt_count  out  16  packets committed; wraps.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, while reset=1 at a clock edge:
  - Next-cycle values: s_ready=0, buf_in_wren=0, buf_in_commit=0, buf_in_addr=0, buf_in_data=0, buf_in_commit_len=0, pkt_count=0, busy=0.
  - Internal state: state=IDLE, len=0, zlp_pend=0.
  - Reset mid-packet or mid-commit drops commit immediately and discards the partial packet. pkt_count is not incremented.
- State IDLE:
  - If buf_in_ready=1 and zlp_pend=1: len<=0, clear zlp_pend, go to COMMIT.
  - Else if buf_in_ready=1: len<=0, go to FILL.
  - Otherwise stay in IDLE.
- State FILL:
  - s_ready=1 combinationally in this state only.
  - On an accepted beat, outputs are registered, giving one cycle of latency: next cycle buf_in_wren=1, buf_in_addr=len[8:0], buf_in_data=s_data. Then len<=len+1.
  - Close the packet (go to COMMIT, commit_len = new len) on either:
    - an accepted beat where len+1==MAX_PKT, or s_last=1, or flush=1;
    - flush=1 with no accepted beat, which uses the current len and may be 0 (ZLP).
  - If the accepted beat has len+1==MAX_PKT, s_last=1 and AUTO_ZLP=1: set zlp_pend.
  - s_last with len+1<MAX_PKT never sets zlp_pend.
  - Back-to-back beats write every cycle. s_ready is 0 from the cycle after the closing beat.
- State COMMIT:
  - buf_in_commit=1 and buf_in_commit_len=len.
  - The final byte's wren has landed by COMMIT's first cycle, so commit never precedes the last write.
  - On buf_in_commit_ack=1: buf_in_commit<=0, pkt_count<=pkt_count+1, go to ACK.
- State ACK: wait for buf_in_commit_ack=0, then go to DRAIN.
- State DRAIN: wait for buf_in_ready=0, meaning the endpoint has swapped or claimed the buffer, then go to IDLE. This prevents reuse of the stale ready high seen during the endpoint's swap cycle.
- Widths and arithmetic:
  - len is 10 bits; buf_in_addr = len[8:0]; len never exceeds MAX_PKT.
  - pkt_count wraps 0xFFFF→0x0000.
- Simultaneous events:
  - flush together with a beat: the beat is written and is the last byte.
  - flush while not in FILL: ignored.
  - ack already high on COMMIT entry: accepted on the first COMMIT cycle.

Test Plan:
- 3-byte packet: MAX_PKT=512, buf_in_ready=1, send 0xA1,0xA2,0xA3 with s_last on 0xA3 → wren at addr 0,1,2 with matching data; commit rises with commit_len=3; commit held until 4-cycle ack, drops on first ack cycle; pkt_count=1; next packet starts after ready 1→0→1.
- Full packet: stream 520 bytes with no s_last → auto commit with commit_len=512 after addr 511; s_ready=0 through COMMIT/ACK/DRAIN; byte 513 written at addr 0 of the next packet; commit_len=8 on flush at the end.
- Auto ZLP: 512 bytes with s_last on the 512th, AUTO_ZLP=1 → commit len 512, then on the next ready a commit with len 0 and no wren; pkt_count=2. With AUTO_ZLP=0 → a single commit.
- Flush empty: enter FILL, assert flush with s_valid=0 → commit_len=0, zero wren pulses.
- Backpressure and reset: hold buf_in_ready=0 → s_ready=0, no wren, busy=0. Assert reset during COMMIT → commit=0 next cycle, pkt_count unchanged (0), state IDLE.
- Ack timing: ack already high when COMMIT entered → commit is a 1-cycle pulse, count increments once. Ack held 10 cycles → no second count.
